// File: rtl/cplx_pkg.sv
// Shared constants and the saturation helper for the complex mixer.
// Default widths match a 16-bit sample path fed by a 32-bit Q16 CORDIC.
package cplx_pkg;

    localparam int C_DW   = 16;
    localparam int C_CW   = 32;
    localparam int C_FRAC = 16;

    // 1.0 in the cos/sin fixed-point format
    localparam longint ONE_Q = 64'sd1 <<< C_FRAC;

    // Clamp a sign-extended value into a signed dw-bit range
    function automatic logic signed [63:0] sat_dw(input logic signed [63:0] v, input int dw);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (dw - 1));
        if (v > hi)
            sat_dw = hi;
        else if (v < lo)
            sat_dw = lo;
        else
            sat_dw = v;
    endfunction

endpackage

// File: rtl/cplx_sat_rnd.sv
// One output rail: optional round-half-up, arithmetic shift by FRAC,
// saturate to DW bits and flag when clamping happened.
// Build option: CPLX_MIXER_ROUND_EN selects rounding; otherwise truncate (floor).
module cplx_sat_rnd
    import cplx_pkg::*;
#(
    parameter int DW   = C_DW,
    parameter int SW   = C_DW + C_CW + 1,
    parameter int FRAC = C_FRAC
) (
    input  logic signed [SW-1:0] i_sum,
    output logic signed [DW-1:0] o_y,
    output logic                 o_ovf
);

    logic signed [SW-1:0] w_rnd;
    logic signed [SW-1:0] w_sh;
    logic signed [63:0]   w_ext;
    logic signed [63:0]   w_sat;

`ifdef CPLX_MIXER_ROUND_EN
    // Half an LSB of the output; headroom in SW keeps this add from wrapping
    localparam logic signed [SW-1:0] RND = {{(SW-FRAC){1'b0}}, 1'b1, {(FRAC-1){1'b0}}};
    assign w_rnd = i_sum + RND;
`else
    assign w_rnd = i_sum;
`endif

    assign w_sh  = w_rnd >>> FRAC;
    assign w_ext = 64'(w_sh);
    assign w_sat = sat_dw(w_ext, DW);
    assign o_y   = w_sat[DW-1:0];
    assign o_ovf = (w_sat != w_ext);

endmodule

// File: rtl/cplx_mixer.sv
// Complex mixer: joins one CORDIC (cos, sin) word with one I/Q sample and
// rotates the sample. 3-stage pipeline: multiply, add/sub, round/saturate.
// Build option: CPLX_MIXER_ROUND_EN (round half up instead of truncate).
module cplx_mixer
    import cplx_pkg::*;
#(
    parameter int DW   = C_DW,
    parameter int CW   = C_CW,
    parameter int FRAC = C_FRAC
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rot_vld_i,
    output logic                 rot_rdy_o,
    input  logic signed [CW-1:0] cos_i,
    input  logic signed [CW-1:0] sin_i,
    input  logic                 s_vld_i,
    output logic                 s_rdy_o,
    input  logic signed [DW-1:0] s_i_i,
    input  logic signed [DW-1:0] s_q_i,
    output logic                 m_vld_o,
    input  logic                 m_rdy_i,
    output logic signed [DW-1:0] m_i_o,
    output logic signed [DW-1:0] m_q_o,
    output logic                 sat_o
);

    localparam int PW = DW + CW;
    localparam int SW = PW + 1;

    logic [3:1]           r_vld;
    logic signed [PW-1:0] r_p_ic, r_p_qs, r_p_is, r_p_qc;
    logic signed [SW-1:0] r_sum_i, r_sum_q;
    logic signed [DW-1:0] r_m_i, r_m_q;
    logic                 r_sat;

    logic                 w_en, w_acc;
    logic signed [DW-1:0] w_y_i, w_y_q;
    logic                 w_ovf_i, w_ovf_q;

    // Whole pipe advances together; gated by reset so nothing handshakes while held
    assign w_en      = !rst && (!r_vld[3] || m_rdy_i);
    // Each side's ready depends only on the partner's valid, never its data
    assign rot_rdy_o = s_vld_i & w_en;
    assign s_rdy_o   = rot_vld_i & w_en;
    assign w_acc     = rot_vld_i & s_vld_i & w_en;

    cplx_sat_rnd #(.DW(DW), .SW(SW), .FRAC(FRAC)) u_sat_i (
        .i_sum (r_sum_i),
        .o_y   (w_y_i),
        .o_ovf (w_ovf_i)
    );

    cplx_sat_rnd #(.DW(DW), .SW(SW), .FRAC(FRAC)) u_sat_q (
        .i_sum (r_sum_q),
        .o_y   (w_y_q),
        .o_ovf (w_ovf_q)
    );

    // Pipeline: valid shift register plus data stages, all frozen when the output stalls
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld <= '0;
            r_m_i <= '0;
            r_m_q <= '0;
            r_sat <= 1'b0;
        end else if (w_en) begin
            r_vld <= {r_vld[2:1], w_acc};
            if (w_acc) begin
                r_p_ic <= PW'(s_i_i) * PW'(cos_i);
                r_p_qs <= PW'(s_q_i) * PW'(sin_i);
                r_p_is <= PW'(s_i_i) * PW'(sin_i);
                r_p_qc <= PW'(s_q_i) * PW'(cos_i);
            end
            if (r_vld[1]) begin
                r_sum_i <= SW'(r_p_ic) - SW'(r_p_qs);
                r_sum_q <= SW'(r_p_is) + SW'(r_p_qc);
            end
            if (r_vld[2]) begin
                r_m_i <= w_y_i;
                r_m_q <= w_y_q;
                r_sat <= r_sat | w_ovf_i | w_ovf_q;
            end
        end
    end

    assign m_vld_o = r_vld[3];
    assign m_i_o   = r_m_i;
    assign m_q_o   = r_m_q;
    assign sat_o   = r_sat;

endmodule

// File: tb/tb_cplx_mixer.sv
// Self-checking bench for cplx_mixer: table of vectors, scoreboard queue
// filled at the accept handshake and drained at the output handshake.
module tb_cplx_mixer;

    logic               clk = 1'b0;
    logic               rst;
    logic               rot_vld_i, rot_rdy_o;
    logic signed [31:0] cos_i, sin_i;
    logic               s_vld_i, s_rdy_o;
    logic signed [15:0] s_i_i, s_q_i;
    logic               m_vld_o, m_rdy_i;
    logic signed [15:0] m_i_o, m_q_o;
    logic               sat_o;

    cplx_mixer dut (
        .clk(clk), .rst(rst),
        .rot_vld_i(rot_vld_i), .rot_rdy_o(rot_rdy_o), .cos_i(cos_i), .sin_i(sin_i),
        .s_vld_i(s_vld_i), .s_rdy_o(s_rdy_o), .s_i_i(s_i_i), .s_q_i(s_q_i),
        .m_vld_o(m_vld_o), .m_rdy_i(m_rdy_i), .m_i_o(m_i_o), .m_q_o(m_q_o),
        .sat_o(sat_o)
    );

    always #5 clk = ~clk;

    typedef struct { int c; int s; int xi; int xq; int ei; int eq; } vec_t;
    typedef struct { int ei; int eq; int cyc; } exp_t;

    exp_t sb[$];
    vec_t tv[12];
    int   n_cmp = 0, n_err = 0, cyc = 0, n_acc = 0, n_out = 0;
    int   pend_ei = 0, pend_eq = 0;
    bit   lat_chk = 1'b1;
    bit   prev_stall = 1'b0;
    logic signed [15:0] prev_i, prev_q;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // Reference: exact integer rotation, then optional rounding, floor shift, clamp
    function automatic void model(input int c, input int s, input int xi, input int xq,
                                  output int ei, output int eq);
        longint yi, yq;
        yi = longint'(xi) * c - longint'(xq) * s;
        yq = longint'(xi) * s + longint'(xq) * c;
`ifdef CPLX_MIXER_ROUND_EN
        yi += 32768;
        yq += 32768;
`endif
        yi = yi >>> 16;
        yq = yq >>> 16;
        if (yi > 32767) yi = 32767;
        if (yi < -32768) yi = -32768;
        if (yq > 32767) yq = 32767;
        if (yq < -32768) yq = -32768;
        ei = int'(yi);
        eq = int'(yq);
    endfunction

    // Monitor sits on the falling edge, where handshakes for the next rise are settled
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            sb.delete();
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_hold_vld", longint'(m_vld_o), 1);
                chk("stall_hold_i", longint'(m_i_o), longint'(prev_i));
                chk("stall_hold_q", longint'(m_q_o), longint'(prev_q));
            end
            if (rot_vld_i && s_vld_i && rot_rdy_o && s_rdy_o) begin
                n_acc++;
                sb.push_back('{pend_ei, pend_eq, cyc});
            end
            if (m_vld_o && m_rdy_i) begin
                n_out++;
                if (sb.size() == 0) begin
                    chk("unexpected_output", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("out_i", longint'(m_i_o), longint'(e.ei));
                    chk("out_q", longint'(m_q_o), longint'(e.eq));
                    if (lat_chk) chk("latency", longint'(cyc - e.cyc), 3);
                end
            end
            prev_stall = m_vld_o && !m_rdy_i;
            prev_i     = m_i_o;
            prev_q     = m_q_o;
        end
    end

    // Present one pair and hold it until the join accepts it (bounded)
    task automatic send(input vec_t v);
        bit got;
        int tmo;
        cos_i = v.c; sin_i = v.s; s_i_i = 16'(v.xi); s_q_i = 16'(v.xq);
        pend_ei = v.ei; pend_eq = v.eq;
        rot_vld_i = 1'b1; s_vld_i = 1'b1;
        tmo = 0;
        do begin
            @(negedge clk);
            got = rot_rdy_o && s_rdy_o;
            if (!got) tmo++;
            @(posedge clk); #1;
        end while (!got && tmo < 50);
        if (!got) chk("send_timeout", 0, 1);
        rot_vld_i = 1'b0; s_vld_i = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (sb.size() > 0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (sb.size() > 0) chk("drain_timeout", longint'(sb.size()), 0);
        @(posedge clk); #1;
    endtask

    initial begin
        int base, o0;
        vec_t v5;
        rst = 1'b1; m_rdy_i = 1'b1;
        rot_vld_i = 1'b1; s_vld_i = 1'b1;
        cos_i = 65536; sin_i = 0; s_i_i = 16'sd100; s_q_i = 16'sd100;

        tv[0] = '{65536, 0, 1000, -2000, 1000, -2000};
        tv[1] = '{0, 65536, 1000, -2000, 2000, 1000};
        tv[2] = '{65536, 0, -32768, 0, -32768, 0};
`ifdef CPLX_MIXER_ROUND_EN
        tv[3] = '{32768, 0, 3, 0, 2, 0};
`else
        tv[3] = '{32768, 0, 3, 0, 1, 0};
`endif
        for (int i = 4; i < 12; i++) begin
            tv[i].c  = int'($urandom_range(92000)) - 46000;
            tv[i].s  = int'($urandom_range(92000)) - 46000;
            tv[i].xi = int'($urandom_range(32000)) - 16000;
            tv[i].xq = int'($urandom_range(32000)) - 16000;
            model(tv[i].c, tv[i].s, tv[i].xi, tv[i].xq, tv[i].ei, tv[i].eq);
        end

        // Reset held with both inputs valid: no handshakes, outputs quiet
        repeat (3) begin
            @(negedge clk);
            chk("rst_rot_rdy", longint'(rot_rdy_o), 0);
            chk("rst_s_rdy", longint'(s_rdy_o), 0);
            chk("rst_m_vld", longint'(m_vld_o), 0);
            chk("rst_sat", longint'(sat_o), 0);
        end
        @(posedge clk); #1;
        rst = 1'b0; rot_vld_i = 1'b0; s_vld_i = 1'b0;
        chk("rst_m_i", longint'(m_i_o), 0);

        // Unit rotations, full-scale boundary and rounding mode
        for (int i = 0; i < 4; i++) begin
            send(tv[i]);
            drain();
        end
        chk("no_sat_yet", longint'(sat_o), 0);

        // CORDIC valid alone must not be consumed
        base = n_acc;
        rot_vld_i = 1'b1; s_vld_i = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("join_rot_rdy_low", longint'(rot_rdy_o), 0);
        end
        @(posedge clk); #1;
        chk("join_no_accept", longint'(n_acc), longint'(base));
        send(tv[0]);
        drain();
        chk("join_one_accept", longint'(n_acc), longint'(base + 1));

        // Back-to-back stream with a 4-cycle output stall in the middle
        lat_chk = 1'b0;
        o0 = n_out;
        fork
            begin
                for (int i = 4; i < 12; i++) send(tv[i]);
            end
            begin
                repeat (5) @(posedge clk);
                #1 m_rdy_i = 1'b0;
                repeat (4) @(posedge clk);
                #1 m_rdy_i = 1'b1;
            end
        join
        drain();
        chk("stream_count", longint'(n_out - o0), 8);
        lat_chk = 1'b1;

        // 45 degrees at full scale: I cancels, Q clips
        v5 = '{46341, 46341, 32767, 32767, 0, 32767};
        send(v5);
        drain();
        chk("sat_set", longint'(sat_o), 1);

        // Reset with two pairs in flight: they must never appear
        send(tv[0]);
        send(tv[1]);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (6) begin
            @(negedge clk);
            chk("midrst_no_out", longint'(m_vld_o), 0);
        end
        chk("midrst_sat_clr", longint'(sat_o), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
